// File: rtl/clb_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clb_cfg_pkg
// Purpose  : Shared constants and types for the CLB configuration loader.
//            Holds the configuration word width, the bit positions of each
//            configuration field, the FF-enable source encodings and the
//            loader state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clb_cfg_pkg;

    // Configuration word width and field bounds.
    localparam int CFG_W       = 23;
    localparam int OUT_SEL_HI  = 22;
    localparam int OUT_SEL_LO  = 19;
    localparam int OMUX_BIT    = 18;
    localparam int FFEN_HI     = 17;
    localparam int FFEN_LO     = 16;
    localparam int LUT_HI      = 15;
    localparam int LUT_LO      = 0;

    // FF enable source select encodings.
    localparam logic [1:0] FFEN_LEFT   = 2'b00;
    localparam logic [1:0] FFEN_RIGHT  = 2'b01;
    localparam logic [1:0] FFEN_ALWAYS = 2'b10;
    localparam logic [1:0] FFEN_UP     = 2'b11;

    // Bit counter sizing: 23 bits per word, counted 0..22.
    localparam int         BIT_CNT_W = 5;
    localparam logic [4:0] LAST_BIT  = 5'd22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } cfg_state_t;

    // Field view of one configuration word, MSB first.
    typedef struct packed {
        logic [OUT_SEL_HI-OUT_SEL_LO:0] out_sel;
        logic                           omux;
        logic [FFEN_HI-FFEN_LO:0]       ffen;
        logic [LUT_HI-LUT_LO:0]         lut;
    } clb_cfg_t;

    // Reinterpret a raw shifted word as its fields.
    function automatic clb_cfg_t unpack_cfg(input logic [CFG_W-1:0] word);
        return clb_cfg_t'(word);
    endfunction

endpackage : clb_cfg_pkg
`default_nettype wire

// File: rtl/clb_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : clb_cfg_loader_if
// Purpose  : Bitstream handshake plus CLB configuration bus bundle.
//            master : bitstream source side (drives start/bit/valid)
//            slave  : loader side (drives ready, config bus and status)
// Signals  : cfg_start, cfg_bit, cfg_valid, cfg_ready,
//            clb_bits[CFG_W], clb_wr_en[NUM_CLB], frame_idx[IDX_W],
//            busy, done, err
// Revision : 1.0 - initial release
// ============================================================================
interface clb_cfg_loader_if
    import clb_cfg_pkg::*;
#(
    parameter int NUM_CLB = 16,
    parameter int IDX_W   = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1
) ();

    logic               cfg_start;
    logic               cfg_bit;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CFG_W-1:0]   clb_bits;
    logic [NUM_CLB-1:0] clb_wr_en;
    logic [IDX_W-1:0]   frame_idx;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cfg_start, cfg_bit, cfg_valid,
        input  cfg_ready, clb_bits, clb_wr_en, frame_idx, busy, done, err
    );

    modport slave (
        input  cfg_start, cfg_bit, cfg_valid,
        output cfg_ready, clb_bits, clb_wr_en, frame_idx, busy, done, err
    );

endinterface : clb_cfg_loader_if
`default_nettype wire

// File: rtl/clb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : clb_cfg_loader
// Purpose  : Serial configuration loader for the CLB array. Shifts in the
//            bitstream MSB first, assembles 23-bit words and writes each one
//            to its CLB (ascending index) with a one-cycle one-hot strobe.
// Ports    : clk  - fabric clock
//            rst  - synchronous active-high reset
//            bus  - clb_cfg_loader_if.slave (handshake, config bus, status)
// Revision : 1.0 - initial release
// ============================================================================
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int NUM_CLB = 16,
    parameter int IDX_W   = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    clb_cfg_loader_if.slave     bus
);

    localparam logic [IDX_W-1:0] LAST_FRAME = IDX_W'(NUM_CLB - 1);

    cfg_state_t             r_state;
    logic [CFG_W-1:0]       r_sr;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [IDX_W-1:0]       r_frame_idx;
    logic [NUM_CLB-1:0]     r_wr_en;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic [NUM_CLB-1:0]     w_frame_onehot;
    logic                   w_accept;

    assign w_frame_onehot = NUM_CLB'(1) << r_frame_idx;
    // r_ready is only high in SHIFT, so this also qualifies on state.
    assign w_accept       = bus.cfg_valid && r_ready;

    // All outputs come straight from registers; the strobe and ready are
    // computed one cycle ahead so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_frame_idx <= '0;
            r_wr_en     <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Strobe is a single-cycle pulse; only the SHIFT->WRITE step sets it.
            r_wr_en <= '0;

            case (r_state)
                IDLE, DONE: begin
                    if (bus.cfg_start) begin
                        r_state     <= SHIFT;
                        r_bit_cnt   <= '0;
                        r_frame_idx <= '0;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (bus.cfg_start) begin
                        // Abort and restart; a bit presented alongside the
                        // start pulse is dropped.
                        r_bit_cnt   <= '0;
                        r_frame_idx <= '0;
                        r_err       <= 1'b1;
                    end else if (w_accept) begin
                        r_sr <= {r_sr[CFG_W-2:0], bus.cfg_bit};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= WRITE;
                            r_ready   <= 1'b0;
                            r_wr_en   <= w_frame_onehot;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                WRITE: begin
                    // The strobe is already out for this cycle, so a start
                    // here lets the current write land and restarts after it.
                    if (bus.cfg_start) begin
                        r_state     <= SHIFT;
                        r_bit_cnt   <= '0;
                        r_frame_idx <= '0;
                        r_ready     <= 1'b1;
                        r_err       <= 1'b1;
                    end else if (r_frame_idx == LAST_FRAME) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= SHIFT;
                        r_frame_idx <= r_frame_idx + IDX_W'(1);
                        r_ready     <= 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = r_ready;
    assign bus.clb_bits  = r_sr;
    assign bus.clb_wr_en = r_wr_en;
    assign bus.frame_idx = r_frame_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule : clb_cfg_loader
`default_nettype wire

// File: tb/tb_clb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_clb_cfg_loader
// Purpose  : Self-checking bench for clb_cfg_loader with a 4-CLB array.
//            A monitor logs every write strobe (target, data, clock edge);
//            directed sequences compare the log and status outputs against
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clb_cfg_loader;

    localparam int N = 4;

    logic clk;
    logic rst;

    clb_cfg_loader_if #(.NUM_CLB(N)) bus ();

    clb_cfg_loader #(.NUM_CLB(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] word;
        logic [3:0]  exp_wr_en;
        int          exp_edge;   // posedge (relative to the start edge) after which the strobe is visible
    } vec_t;

    vec_t        vecs[4];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_cnt[4];
    logic [22:0] wr_data[4];
    logic [3:0]  wr_mask[4];
    int          wr_edge[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_log();
        for (int k = 0; k < N; k++) begin
            wr_cnt[k]  = 0;
            wr_data[k] = '0;
            wr_mask[k] = '0;
            wr_edge[k] = -1;
        end
    endtask

    // Write monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (bus.clb_wr_en != '0) begin
            chk("wr_onehot", 32'($countones(bus.clb_wr_en)), 32'd1);
            for (int b = 0; b < N; b++) begin
                if (bus.clb_wr_en[b]) begin
                    wr_cnt[b]  = wr_cnt[b] + 1;
                    wr_data[b] = bus.clb_bits;
                    wr_mask[b] = bus.clb_wr_en;
                    wr_edge[b] = cyc;
                end
            end
        end
    end

    // Present the top nbits of w MSB first. Called and returns at a negedge;
    // acc_edge is the edge number at which the final bit was taken.
    task automatic send(input logic [22:0] w, input int nbits, input bit stall,
                        output int acc_edge);
        int i     = 22;
        int stop  = 22 - nbits;
        int guard = 0;
        acc_edge  = -1;
        while (i > stop) begin
            if (guard > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got %0d bits left expected 0", i - stop);
                break;
            end
            guard++;
            if (stall && ($urandom_range(0, 1) == 0)) begin
                bus.cfg_valid = 1'b0;
            end else begin
                bus.cfg_valid = 1'b1;
                bus.cfg_bit   = w[i];
                if (bus.cfg_ready) begin
                    acc_edge = cyc + 1;
                    i--;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int acc;
        int acc_s[4];

        vecs[0] = '{23'h000001, 4'b0001, 23};
        vecs[1] = '{23'h7FFFFF, 4'b0010, 47};
        vecs[2] = '{23'h2AAAAA, 4'b0100, 71};
        vecs[3] = '{23'h555555, 4'b1000, 95};

        clear_log();
        rst           = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = 1'b1;

        // ---------------- reset and idle ----------------
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ready",  32'(bus.cfg_ready), 32'd0);
        chk("idle_busy",   32'(bus.busy),      32'd0);
        chk("idle_done",   32'(bus.done),      32'd0);
        chk("idle_err",    32'(bus.err),       32'd0);
        chk("idle_wr_en",  32'(bus.clb_wr_en), 32'd0);
        chk("idle_bits",   32'(bus.clb_bits),  32'd0);
        chk("idle_frame",  32'(bus.frame_idx), 32'd0);
        bus.cfg_valid = 1'b0;

        // ---------------- full continuous load ----------------
        clear_log();
        pulse_start();
        t0 = cyc;
        chk("load_busy",  32'(bus.busy),      32'd1);
        chk("load_ready", 32'(bus.cfg_ready), 32'd1);
        for (int k = 0; k < N; k++) send(vecs[k].word, 23, 1'b0, acc);
        chk("load_pre_done", 32'(bus.done), 32'd0);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        chk("load_done_edge", 32'(cyc - t0),     32'd96);
        chk("load_done",      32'(bus.done),     32'd1);
        chk("load_err",       32'(bus.err),      32'd0);
        chk("load_busy_end",  32'(bus.busy),     32'd0);
        chk("load_frame_end", 32'(bus.frame_idx), 32'd3);
        for (int k = 0; k < N; k++) begin
            chk("load_wr_cnt",  32'(wr_cnt[k]),        32'd1);
            chk("load_wr_data", 32'(wr_data[k]),       32'(vecs[k].word));
            chk("load_wr_mask", 32'(wr_mask[k]),       32'(vecs[k].exp_wr_en));
            chk("load_wr_edge", 32'(wr_edge[k] - t0),  32'(vecs[k].exp_edge));
        end

        // ---------------- load with random stalls ----------------
        clear_log();
        pulse_start();
        for (int k = 0; k < N; k++) send(vecs[k].word, 23, 1'b1, acc_s[k]);
        bus.cfg_valid = 1'b0;
        for (int g = 0; g < 4 && !bus.done; g++) @(negedge clk);
        chk("stall_done", 32'(bus.done), 32'd1);
        for (int k = 0; k < N; k++) begin
            chk("stall_wr_cnt",  32'(wr_cnt[k]),  32'd1);
            chk("stall_wr_data", 32'(wr_data[k]), 32'(vecs[k].word));
            chk("stall_wr_edge", 32'(wr_edge[k]), 32'(acc_s[k]));
        end

        // ---------------- abort in SHIFT of frame 2 ----------------
        pulse_start();
        send(vecs[0].word, 23, 1'b0, acc);
        send(vecs[1].word, 23, 1'b0, acc);
        send(vecs[2].word, 10, 1'b0, acc);
        bus.cfg_valid = 1'b1;   // bit offered with the start pulse is dropped
        bus.cfg_bit   = 1'b1;
        pulse_start();
        chk("abort_err",   32'(bus.err),       32'd1);
        chk("abort_frame", 32'(bus.frame_idx), 32'd0);
        chk("abort_busy",  32'(bus.busy),      32'd1);
        clear_log();
        send(23'h3C5A96, 23, 1'b0, acc);
        chk("abort_clb0_cnt",  32'(wr_cnt[0]),  32'd1);
        chk("abort_clb0_data", 32'(wr_data[0]), 32'h3C5A96);
        chk("abort_clb2_cnt",  32'(wr_cnt[2]),  32'd0);
        for (int k = 1; k < N; k++) send(vecs[k].word, 23, 1'b0, acc);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        chk("abort_done",     32'(bus.done), 32'd1);
        chk("abort_err_held", 32'(bus.err),  32'd1);
        pulse_start();
        chk("restart_err_clr",  32'(bus.err),  32'd0);
        chk("restart_done_clr", 32'(bus.done), 32'd0);
        chk("restart_busy",     32'(bus.busy), 32'd1);

        // ---------------- start coincident with WRITE of frame 1 ----------------
        clear_log();
        send(vecs[0].word, 23, 1'b0, acc);
        send(vecs[1].word, 23, 1'b0, acc);
        chk("wrstart_wr_en", 32'(bus.clb_wr_en), 32'b0010);
        bus.cfg_valid = 1'b0;
        pulse_start();
        chk("wrstart_err",      32'(bus.err),       32'd1);
        chk("wrstart_frame",    32'(bus.frame_idx), 32'd0);
        chk("wrstart_ready",    32'(bus.cfg_ready), 32'd1);
        chk("wrstart_clb1_cnt", 32'(wr_cnt[1]),     32'd1);
        chk("wrstart_clb1_dat", 32'(wr_data[1]),    32'(vecs[1].word));
        clear_log();
        send(23'h1234AB, 23, 1'b0, acc);
        chk("wrstart_clb0_cnt", 32'(wr_cnt[0]),  32'd1);
        chk("wrstart_clb0_dat", 32'(wr_data[0]), 32'h1234AB);
        chk("wrstart_clb1_re",  32'(wr_cnt[1]),  32'd0);
        bus.cfg_valid = 1'b0;

        // ---------------- reset mid-SHIFT of frame 3 ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        for (int k = 0; k < 3; k++) send(vecs[k].word, 23, 1'b0, acc);
        send(vecs[3].word, 10, 1'b0, acc);
        clear_log();
        rst = 1'b1;             // cfg_valid stays high throughout
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
        chk("rst_frame", 32'(bus.frame_idx), 32'd0);
        chk("rst_wr_en", 32'(bus.clb_wr_en), 32'd0);
        repeat (30) @(negedge clk);
        chk("rst_clb3_cnt", 32'(wr_cnt[3]), 32'd0);
        chk("rst_idle_busy", 32'(bus.busy), 32'd0);
        bus.cfg_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clb_cfg_loader
`default_nettype wire
